// File: rtl/bomb_controller_if.sv
// Signal bundle between the bomb game sequencer and its surroundings:
// switches and puzzle modules on one side, the countdown timer on the other.
interface bomb_controller_if #(
  parameter int NUM_MODULES = 4
);
  logic                   start;
  logic [NUM_MODULES-1:0] solved;
  logic                   strike;
  logic                   timer_zero;
  logic                   timer_load;
  logic [15:0]            load_seconds;
  logic                   timer_tick;
  logic [1:0]             strikes;
  logic [1:0]             state;
  logic                   strike_flash;
  logic [7:0]             led;

  modport slave (
    input  start, solved, strike, timer_zero,
    output timer_load, load_seconds, timer_tick, strikes, state, strike_flash, led
  );

  modport master (
    output start, solved, strike, timer_zero,
    input  timer_load, load_seconds, timer_tick, strikes, state, strike_flash, led
  );
endinterface

// File: rtl/bomb_controller.sv
// KTNE bomb game sequencer: arms the countdown, paces its ticks (faster with
// each strike), tracks strikes and solved modules, and decides defuse/explode.
module bomb_controller #(
  parameter int NUM_MODULES   = 4,
  parameter int START_SECONDS = 300,
  parameter int TICK_CYCLES   = 100_000_000,
  parameter int MAX_STRIKES   = 3,
  parameter int FLASH_CYCLES  = 25_000_000
) (
  input logic              clk,
  input logic              rst,
  bomb_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    DEFUSED  = 2'b10,
    EXPLODED = 2'b11
  } state_t;

  localparam int CW = $clog2(TICK_CYCLES);
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  // Terminal count (period - 1) for 0, 1 and 2+ strikes.
  localparam logic [CW-1:0] LIM_0       = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] LIM_1       = CW'(TICK_CYCLES - TICK_CYCLES / 4 - 1);
  localparam logic [CW-1:0] LIM_2       = CW'(TICK_CYCLES / 2 - 1);
  localparam logic [FW-1:0] FLASH_LOAD  = FW'(FLASH_CYCLES);
  localparam logic [1:0]    STRIKE_CAP  = 2'(MAX_STRIKES);
  localparam logic [1:0]    LAST_STRIKE = 2'(MAX_STRIKES - 1);

  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx, lim_s;
  logic [FW-1:0] flash_cnt_r, flash_cnt_nx;
  logic [1:0]    strikes_r, strikes_nx;
  logic [3:0]    mask_r, mask_nx;
  logic [7:0]    led_r, led_nx;
  logic          load_r, load_nx;
  logic          tick_r, tick_nx;
  logic          flash_r, flash_nx;
  logic          accept_s;

  assign accept_s = (state_r == ARMED) && bus.strike;
  assign lim_s    = (strikes_r == 2'd0) ? LIM_0 :
                    (strikes_r == 2'd1) ? LIM_1 : LIM_2;

  // Next-state decision and next values of every registered output.
  always_comb begin
    state_nx     = state_r;
    strikes_nx   = strikes_r;
    cnt_nx       = {CW{1'b0}};
    tick_nx      = 1'b0;
    load_nx      = 1'b0;
    flash_cnt_nx = flash_cnt_r;
    flash_nx     = 1'b0;
    mask_nx      = mask_r;

    case (state_r)
      IDLE: begin
        if (bus.start) state_nx = ARMED;
        else           state_nx = IDLE;
      end
      ARMED: begin
        // The timer's zero flag is stale during the load cycle, so it is ignored there.
        if (accept_s && (strikes_r == LAST_STRIKE)) state_nx = EXPLODED;
        else if (bus.timer_zero && !load_r)         state_nx = EXPLODED;
        else if (&bus.solved)                       state_nx = DEFUSED;
        else                                        state_nx = ARMED;
      end
      DEFUSED, EXPLODED: begin
        if (bus.start) state_nx = IDLE;
        else           state_nx = state_r;
      end
      default: state_nx = IDLE;
    endcase

    if ((state_r == IDLE) && bus.start) load_nx = 1'b1;
    else                                load_nx = 1'b0;

    if (state_nx == IDLE)                           strikes_nx = 2'd0;
    else if (accept_s && (strikes_r != STRIKE_CAP)) strikes_nx = strikes_r + 2'd1;
    else                                            strikes_nx = strikes_r;

    // ">=" also covers a strike shrinking the period below the running count.
    if ((state_r == ARMED) && (state_nx == ARMED)) begin
      if (cnt_r >= lim_s) begin
        cnt_nx  = {CW{1'b0}};
        tick_nx = 1'b1;
      end else begin
        cnt_nx  = cnt_r + CW'(1'b1);
        tick_nx = 1'b0;
      end
    end else begin
      cnt_nx  = {CW{1'b0}};
      tick_nx = 1'b0;
    end

    if (accept_s) begin
      flash_cnt_nx = FLASH_LOAD;
      flash_nx     = 1'b1;
    end else if (state_nx == IDLE) begin
      flash_cnt_nx = {FW{1'b0}};
      flash_nx     = 1'b0;
    end else if (flash_cnt_r != {FW{1'b0}}) begin
      flash_cnt_nx = flash_cnt_r - FW'(1'b1);
      flash_nx     = (flash_cnt_r > FW'(1'b1));
    end else begin
      flash_cnt_nx = {FW{1'b0}};
      flash_nx     = 1'b0;
    end

    if ((state_r == ARMED) || (state_nx == ARMED)) mask_nx = 4'(bus.solved[NUM_MODULES-1:0]);
    else if (state_nx == IDLE)                     mask_nx = 4'b0000;
    else                                           mask_nx = mask_r;

    led_nx = {(state_nx == EXPLODED) || flash_nx, state_nx == DEFUSED, strikes_nx, mask_nx};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      strikes_r   <= 2'd0;
      cnt_r       <= {CW{1'b0}};
      tick_r      <= 1'b0;
      load_r      <= 1'b0;
      flash_cnt_r <= {FW{1'b0}};
      flash_r     <= 1'b0;
      mask_r      <= 4'b0000;
      led_r       <= 8'h00;
    end else begin
      state_r     <= state_nx;
      strikes_r   <= strikes_nx;
      cnt_r       <= cnt_nx;
      tick_r      <= tick_nx;
      load_r      <= load_nx;
      flash_cnt_r <= flash_cnt_nx;
      flash_r     <= flash_nx;
      mask_r      <= mask_nx;
      led_r       <= led_nx;
    end
  end

  assign bus.timer_load   = load_r;
  assign bus.load_seconds = 16'(START_SECONDS);
  assign bus.timer_tick   = tick_r;
  assign bus.strikes      = strikes_r;
  assign bus.state        = state_r;
  assign bus.strike_flash = flash_r;
  assign bus.led          = led_r;

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: a cycle-level game model plus a small countdown
// timer, compared every cycle, with hand-computed spot checks on key cycles.
module tb_bomb_controller;

  localparam int TC    = 8;
  localparam int SECS  = 5;
  localparam int MAXS  = 3;
  localparam int FLASH = 4;

  typedef struct packed {
    logic [1:0] st;
    int         strikes;
    int         age;
    int         flash;
    logic [3:0] mask;
    logic       load;
    logic       tick;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tz_force = 1'b0;
  logic [15:0] tsec = 16'd0;
  int          cyc = 0;
  int          t_arm = 0;
  int          n_chk = 0;
  int          n_err = 0;
  mdl_t        m = '0;

  bomb_controller_if #(.NUM_MODULES(4)) bus ();

  bomb_controller #(
    .NUM_MODULES(4), .START_SECONDS(SECS), .TICK_CYCLES(TC),
    .MAX_STRIKES(MAXS), .FLASH_CYCLES(FLASH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Countdown timer the controller talks to.
  always @(posedge clk) begin
    if (bus.timer_load)                          tsec <= 16'(SECS);
    else if (bus.timer_tick && tsec != 16'd0)    tsec <= tsec - 16'd1;
    else                                         tsec <= tsec;
  end
  assign bus.timer_zero = tz_force || (tsec == 16'd0);

  function automatic int period(int s);
    if (s == 0)      return TC;
    else if (s == 1) return TC - TC / 4;
    else             return TC / 2;
  endfunction

  // Game rules: how the model moves from one cycle to the next.
  function automatic mdl_t step(mdl_t c, logic go, logic [3:0] sol, logic hit, logic tz);
    mdl_t n = c;
    n.load = 1'b0;
    n.tick = 1'b0;
    case (c.st)
      2'd0: if (go) begin n.st = 2'd1; n.load = 1'b1; n.age = 1; n.mask = sol; end
      2'd1: begin
        if (hit) begin
          n.strikes = (c.strikes < MAXS) ? c.strikes + 1 : c.strikes;
          n.flash   = FLASH;
        end else if (c.flash > 0) n.flash = c.flash - 1;
        if (hit && (c.strikes + 1 == MAXS)) n.st = 2'd3;
        else if (tz && !c.load)             n.st = 2'd3;
        else if (sol == 4'hF)               n.st = 2'd2;
        if (n.st == 2'd1) begin
          if (c.age >= period(c.strikes)) begin n.tick = 1'b1; n.age = 1; end
          else n.age = c.age + 1;
        end
        n.mask = sol;
      end
      default: begin
        if (go) n = '0;
        else if (c.flash > 0) n.flash = c.flash - 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [7:0] led_of(mdl_t c);
    return {(c.st == 2'd3) || (c.flash > 0), c.st == 2'd2, 2'(c.strikes), c.mask};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= step(m, bus.start, bus.solved, bus.strike, bus.timer_zero);
  end

  task automatic chk(string name, int act, int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, want);
    end
  endtask

  // Per-cycle comparison against the model.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      chk("cmp_state",        bus.state,        m.st);
      chk("cmp_strikes",      bus.strikes,      m.strikes);
      chk("cmp_timer_load",   bus.timer_load,   m.load);
      chk("cmp_timer_tick",   bus.timer_tick,   m.tick);
      chk("cmp_strike_flash", bus.strike_flash, m.flash > 0);
      chk("cmp_led",          bus.led,          led_of(m));
      chk("cmp_load_seconds", bus.load_seconds, SECS);
    end
  end

  task automatic at_cycle(int k);
    while (cyc < t_arm + k - 1) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic arm();
    pulse_start();
    t_arm = cyc;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.solved = 4'b0000;
    bus.strike = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_led", bus.led, 0);
    chk("rst_load_seconds", bus.load_seconds, 5);
    rst = 1'b1;

    // Free-running countdown to timeout.
    arm();
    chk("b_state_armed", bus.state, 1);
    chk("b_load_first", bus.timer_load, 1);
    at_cycle(2);  chk("b_load_gone", bus.timer_load, 0); chk("b_stale_zero", bus.state, 1);
    at_cycle(8);  chk("b_no_tick8", bus.timer_tick, 0);
    at_cycle(9);  chk("b_tick9", bus.timer_tick, 1);
    at_cycle(10); chk("b_no_tick10", bus.timer_tick, 0);
    at_cycle(42); chk("b_still_armed", bus.state, 1);
    at_cycle(43); chk("b_exploded", bus.state, 3); chk("b_led", bus.led, 8'h80);
    at_cycle(50); chk("b_no_tick_after", bus.timer_tick, 0);

    // Asynchronous reset in the middle of a countdown.
    pulse_start();
    chk("c_idle", bus.state, 0);
    arm();
    at_cycle(5);
    #3 rst = 1'b0;
    #1;
    chk("c_rst_state", bus.state, 0);
    chk("c_rst_strikes", bus.strikes, 0);
    chk("c_rst_led", bus.led, 0);
    chk("c_rst_tick", bus.timer_tick, 0);
    @(negedge clk) rst = 1'b1;
    arm();
    chk("c_rearm_load", bus.timer_load, 1);

    // Strikes speed the tick up: 8 -> 6 -> 4, then the third strike explodes.
    at_cycle(3);  bus.strike = 1'b1;
    at_cycle(4);  bus.strike = 1'b0;
    chk("d_strikes1", bus.strikes, 1); chk("d_flash1", bus.strike_flash, 1); chk("d_led1", bus.led, 8'h90);
    at_cycle(7);  chk("d_tick7", bus.timer_tick, 1);
    at_cycle(8);  chk("d_flash_end", bus.strike_flash, 0); chk("d_led_after", bus.led, 8'h10);
    at_cycle(13); chk("d_tick13", bus.timer_tick, 1);
    at_cycle(23); bus.strike = 1'b1;
    at_cycle(24); bus.strike = 1'b0;
    chk("d_strikes2", bus.strikes, 2); chk("d_led2", bus.led, 8'hA0);
    at_cycle(25); chk("d_tick25", bus.timer_tick, 1);
    at_cycle(28); chk("d_flash2_end", bus.strike_flash, 0); chk("d_led28", bus.led, 8'h20);
    at_cycle(29); chk("d_tick29", bus.timer_tick, 1);
    at_cycle(30); bus.strike = 1'b1;
    at_cycle(31); bus.strike = 1'b0;
    chk("d_exploded", bus.state, 3); chk("d_strikes3", bus.strikes, 3); chk("d_led3", bus.led, 8'hB0);
    at_cycle(32); bus.strike = 1'b1;
    at_cycle(33); bus.strike = 1'b0;
    chk("d_strike_ignored", bus.strikes, 3); chk("d_no_tick33", bus.timer_tick, 0);
    at_cycle(35); chk("d_flash3_end", bus.strike_flash, 0); chk("d_led_final", bus.led, 8'hB0);

    // Defuse by solving every module before timeout.
    pulse_start();
    chk("e_idle", bus.state, 0); chk("e_idle_strikes", bus.strikes, 0); chk("e_idle_led", bus.led, 0);
    arm();
    at_cycle(2); bus.solved = 4'b0001;
    at_cycle(3); chk("e_led_mask1", bus.led, 8'h01); bus.solved = 4'b0011;
    at_cycle(4); bus.solved = 4'b0111;
    at_cycle(5); bus.solved = 4'b1111;
    at_cycle(6); chk("e_defused", bus.state, 2); chk("e_led", bus.led, 8'h4F); bus.solved = 4'b0000;
    at_cycle(8); chk("e_led_frozen", bus.led, 8'h4F);
    at_cycle(9); chk("e_no_tick", bus.timer_tick, 0);
    pulse_start();
    chk("e_back_idle", bus.state, 0); chk("e_idle_led2", bus.led, 0);

    // Third strike together with all-solved; stale zero flag on the load cycle.
    arm();
    tz_force = 1'b1;
    at_cycle(2); tz_force = 1'b0;
    chk("f_armed", bus.state, 1); chk("f_strikes0", bus.strikes, 0);
    at_cycle(3); bus.strike = 1'b1;
    at_cycle(4); bus.strike = 1'b0;
    at_cycle(5); bus.strike = 1'b1;
    at_cycle(6); bus.strike = 1'b0;
    chk("f_strikes2", bus.strikes, 2);
    at_cycle(7); bus.strike = 1'b1; bus.solved = 4'b1111;
    at_cycle(8); bus.strike = 1'b0; bus.solved = 4'b0000;
    chk("f_explode_wins", bus.state, 3); chk("f_strikes3", bus.strikes, 3); chk("f_led", bus.led, 8'hBF);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
